// File: rtl/irq_pkg.sv
// Shared constants, FSM encoding and the priority-select helper for the
// four-line interrupt latch.
package irq_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  // Index of the highest set bit; bit NUM_IRQ-1 has the highest priority.
  // Returns 0 for an all-zero vector (callers only use it when non-zero).
  function automatic logic [ID_W-1:0] top_index(input logic [NUM_IRQ-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser plus rising-edge detector. The rise output is a
// single-cycle pulse derived only from flops, so it carries no path from
// the raw asynchronous input.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw level through the synchroniser and remember the last
  // synchronised value for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_latch4.sv
// Four-line interrupt front end: synchronise and edge-detect each request,
// latch it as pending, and present the highest-priority unmasked pending
// line to the consumer through a registered valid/ack handshake.
module irq_latch4
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  input  logic               irq_ack_i,
  output logic [NUM_IRQ-1:0] pend_o,
  output logic               irq_valid_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [NUM_IRQ-1:0] overrun_o
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] overrun_q;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    id_q;
  logic               valid_q;
  logic               ack_fire;
  logic               load_id;
  state_t             state_q;
  state_t             state_d;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (irq_i[g]),
      .rise     (rise[g])
    );
  end

  // Masked lines still latch; they are only kept out of the selection.
  assign eligible = pend_q & ~mask_i;
  assign winner   = top_index(eligible);

  // An ack counts only while a line is actually being presented.
  assign ack_fire = (state_q == PRESENT) && irq_ack_i;
  assign clr      = ack_fire ? (NUM_IRQ'(1) << id_q) : '0;

  // Pending/overrun update. A new edge on a line being cleared wins the
  // pending bit but still clears its overrun flag; an edge on an already
  // pending line is dropped and recorded as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      overrun_q <= '0;
    end else begin
      pend_q    <= rise | (pend_q & ~clr);
      overrun_q <= (overrun_q | (rise & pend_q)) & ~clr;
    end
  end

  // Handshake sequencing: pick a winner in IDLE, hold it until acked,
  // then insert one dead cycle before the next selection.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load_id = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          load_id = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack_i) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, presented id and valid flag; all consumer-facing outputs come
  // straight from these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == PRESENT);
      if (load_id) id_q <= winner;
    end
  end

  assign pend_o      = pend_q;
  assign overrun_o   = overrun_q;
  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;

endmodule

// File: tb/tb_irq_latch4.sv
// Directed bench for irq_latch4. The stimulus thread pushes the ids it
// expects to see presented; a monitor pops them whenever irq_valid_o rises
// and also checks id stability and the dead cycles between windows.
module tb_irq_latch4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq_i = '0;
  logic [3:0] mask_i = '0;
  logic       irq_ack_i = 1'b0;
  logic [3:0] pend_o;
  logic       irq_valid_o;
  logic [1:0] irq_id_o;
  logic [3:0] overrun_o;

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];

  irq_latch4 #(
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq_i),
    .mask_i      (mask_i),
    .irq_ack_i   (irq_ack_i),
    .pend_o      (pend_o),
    .irq_valid_o (irq_valid_o),
    .irq_id_o    (irq_id_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare each new presentation against the scoreboard.
  bit          prev_v   = 1'b0;
  bit          have_win = 1'b0;
  int          low_cnt  = 0;
  int unsigned cur_exp  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v   = 1'b0;
      have_win = 1'b0;
      low_cnt  = 0;
    end else begin
      if (irq_valid_o && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_present", 32'(irq_id_o) + 32'h100, 32'hFFFF);
        end else begin
          cur_exp = exp_q.pop_front();
          check("present_id", 32'(irq_id_o), cur_exp);
        end
        if (have_win) check("gap_cycles_ge2", 32'(low_cnt >= 2), 32'd1);
        have_win = 1'b1;
        low_cnt  = 0;
      end else if (irq_valid_o && prev_v) begin
        check("id_stable", 32'(irq_id_o), cur_exp);
      end
      if (!irq_valid_o) low_cnt++;
      prev_v = irq_valid_o;
    end
  end

  initial begin
    // ---------------- reset with all lines high ----------------
    rst_n = 1'b0;
    irq_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_pend",    32'(pend_o),      32'h0);
      check("rst_valid",   32'(irq_valid_o), 32'h0);
      check("rst_id",      32'(irq_id_o),    32'h0);
      check("rst_overrun", 32'(overrun_o),   32'h0);
    end
    rst_n = 1'b1;
    irq_i = 4'b0000;
    tick(6);
    check("post_rst_pend",  32'(pend_o),      32'h0);
    check("post_rst_valid", 32'(irq_valid_o), 32'h0);

    // ---------------- single request on line 1 ----------------
    exp_q.push_back(1);
    irq_i = 4'b0010;                 // edge 0
    tick(2);
    check("single_pend_e2", 32'(pend_o), 32'h0);
    tick(1);
    check("single_pend_e3",  32'(pend_o),      32'h2);
    check("single_valid_e3", 32'(irq_valid_o), 32'h0);
    tick(1);
    check("single_valid_e4", 32'(irq_valid_o), 32'h1);
    check("single_id_e4",    32'(irq_id_o),    32'h1);
    tick(1);
    irq_ack_i = 1'b1;
    tick(1);                         // edge 6 samples the ack
    irq_ack_i = 1'b0;
    check("single_ack_pend",  32'(pend_o),      32'h0);
    check("single_ack_valid", 32'(irq_valid_o), 32'h0);
    irq_i = 4'b0000;
    tick(4);

    // ---------------- priority and non-preemption ----------------
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    irq_i = 4'b0101;                 // edge 0
    tick(1);
    irq_i = 4'b1101;                 // line 3 pends at edge 4, while id 2 is shown
    tick(3);                         // edge 4
    check("prio_valid_2", 32'(irq_valid_o), 32'h1);
    check("prio_pend_all", 32'(pend_o), 32'hD);
    check("prio_nopreempt", 32'(irq_id_o), 32'h2);
    irq_ack_i = 1'b1;
    tick(1);                         // edge 5
    irq_ack_i = 1'b0;
    check("prio_gap_valid", 32'(irq_valid_o), 32'h0);
    tick(1);                         // edge 6
    check("prio_idle_valid", 32'(irq_valid_o), 32'h0);
    tick(1);                         // edge 7
    check("prio_valid_3", 32'(irq_valid_o), 32'h1);
    check("prio_pend_after2", 32'(pend_o), 32'h9);
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
    tick(2);
    check("prio_valid_0", 32'(irq_valid_o), 32'h1);
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
    check("prio_pend_empty", 32'(pend_o), 32'h0);
    irq_i = 4'b0000;
    tick(4);

    // ---------------- mask ----------------
    mask_i = 4'b1000;
    exp_q.push_back(3);
    irq_i = 4'b1000;
    tick(3);
    check("mask_pend", 32'(pend_o), 32'h8);
    tick(2);
    check("mask_no_valid", 32'(irq_valid_o), 32'h0);
    irq_ack_i = 1'b1;                // stray ack outside PRESENT
    tick(1);
    irq_ack_i = 1'b0;
    check("stray_ack_pend",    32'(pend_o),      32'h8);
    check("stray_ack_overrun", 32'(overrun_o),   32'h0);
    check("stray_ack_valid",   32'(irq_valid_o), 32'h0);
    mask_i = 4'b0000;
    tick(1);
    check("unmask_valid", 32'(irq_valid_o), 32'h1);
    check("unmask_id",    32'(irq_id_o),    32'h3);
    mask_i = 4'b1000;                // masking the presented line keeps it up
    tick(1);
    check("remask_valid", 32'(irq_valid_o), 32'h1);
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
    check("mask_ack_pend",  32'(pend_o),      32'h0);
    check("mask_ack_valid", 32'(irq_valid_o), 32'h0);
    mask_i = 4'b0000;
    irq_i = 4'b0000;
    tick(4);

    // ---------------- overrun ----------------
    mask_i = 4'b0001;                // hold line 0 pending, unpresented
    irq_i = 4'b0001;
    tick(3);
    check("ovr_first_pend", 32'(pend_o), 32'h1);
    irq_i = 4'b0000;
    tick(3);
    irq_i = 4'b0001;
    tick(3);
    check("ovr_flag", 32'(overrun_o), 32'h1);
    check("ovr_pend", 32'(pend_o),    32'h1);
    irq_i = 4'b0000;
    tick(3);

    // ---------------- same-edge set and clear on line 0 ----------------
    irq_i = 4'b0001;                 // rise pulse lands on the ack edge
    tick(1);
    exp_q.push_back(0);
    mask_i = 4'b0000;
    tick(1);
    check("sc_valid", 32'(irq_valid_o), 32'h1);
    irq_ack_i = 1'b1;
    exp_q.push_back(0);
    tick(1);
    irq_ack_i = 1'b0;
    check("sc_pend_kept",    32'(pend_o),      32'h1);
    check("sc_overrun_clr",  32'(overrun_o),   32'h0);
    check("sc_valid_low",    32'(irq_valid_o), 32'h0);
    tick(2);
    check("sc_represent", 32'(irq_valid_o), 32'h1);
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
    check("sc_final_pend",    32'(pend_o),    32'h0);
    check("sc_final_overrun", 32'(overrun_o), 32'h0);
    irq_i = 4'b0000;
    tick(4);

    // ---------------- asynchronous reset mid-PRESENT ----------------
    mask_i = 4'b0100;
    exp_q.push_back(1);
    irq_i = 4'b0110;
    tick(3);
    check("ar_pend", 32'(pend_o), 32'h6);
    irq_i = 4'b0010;
    tick(3);
    irq_i = 4'b0110;
    tick(3);
    check("ar_overrun_pre", 32'(overrun_o),   32'h4);
    check("ar_valid_pre",   32'(irq_valid_o), 32'h1);
    check("ar_id_pre",      32'(irq_id_o),    32'h1);
    #3;
    rst_n = 1'b0;                    // between clock edges
    #1;
    check("ar_valid",   32'(irq_valid_o), 32'h0);
    check("ar_pend0",   32'(pend_o),      32'h0);
    check("ar_overrun", 32'(overrun_o),   32'h0);
    check("ar_id",      32'(irq_id_o),    32'h0);
    tick(1);
    rst_n  = 1'b1;
    irq_i  = 4'b0000;
    mask_i = 4'b0000;
    tick(4);
    check("ar_after_pend", 32'(pend_o), 32'h0);

    // ---------------- drain ----------------
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
